// File: rtl/barrel_shifter_4_bit.sv
// 4-bit registered barrel shifter: logical, rotate and arithmetic shifts by 0-3, one-cycle latency.
// Optional carry_out port and register are built when BARREL_SHIFTER_CARRY_EN is defined.
module barrel_shifter_4_bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] data_in,
    input  logic [1:0] shift_amt,
    input  logic       dir,
    input  logic [1:0] mode,
    output logic [3:0] data_out,
    output logic       out_valid
`ifdef BARREL_SHIFTER_CARRY_EN
    ,
    output logic       carry_out
`endif
);

    localparam logic [1:0] MODE_LOG  = 2'b00;
    localparam logic [1:0] MODE_ROT  = 2'b01;
    localparam logic [1:0] MODE_ARI  = 2'b10;
    localparam logic [1:0] MODE_PASS = 2'b11;

    // Arithmetic left shares the logical zero fill; only arithmetic right replicates the sign.
    function automatic logic [3:0] shift_by1(input logic [3:0] d, input logic right, input logic [1:0] m);
        logic fill;
        if (right) begin
            if (m == MODE_ROT)      fill = d[0];
            else if (m == MODE_ARI) fill = d[3];
            else                    fill = 1'b0;
            shift_by1 = {fill, d[3:1]};
        end else begin
            fill      = (m == MODE_ROT) ? d[3] : 1'b0;
            shift_by1 = {d[2:0], fill};
        end
    endfunction

    function automatic logic [3:0] shift_by2(input logic [3:0] d, input logic right, input logic [1:0] m);
        logic [1:0] fill;
        if (right) begin
            if (m == MODE_ROT)      fill = d[1:0];
            else if (m == MODE_ARI) fill = {2{d[3]}};
            else                    fill = 2'b00;
            shift_by2 = {fill, d[3:2]};
        end else begin
            fill      = (m == MODE_ROT) ? d[3:2] : 2'b00;
            shift_by2 = {d[1:0], fill};
        end
    endfunction

    logic [3:0] stage1;
    logic [3:0] stage2;
    logic [3:0] data_d;
    logic [3:0] data_q;
    logic       vld_q;

    always_comb begin
        stage1 = shift_amt[0] ? shift_by1(data_in, dir, mode) : data_in;
        stage2 = shift_amt[1] ? shift_by2(stage1, dir, mode) : stage1;
        data_d = (mode == MODE_PASS) ? data_in : stage2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= 4'b0000;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                data_q <= data_d;
            end
        end
    end

    assign data_out  = data_q;
    assign out_valid = vld_q;

`ifdef BARREL_SHIFTER_CARRY_EN
    logic carry_d;
    logic carry_q;

    // Carry is the last bit to leave the word; for rotates that bit re-enters at the far end.
    always_comb begin
        carry_d = 1'b0;
        if (mode != MODE_PASS && shift_amt != 2'd0) begin
            if (mode == MODE_ROT) begin
                carry_d = dir ? data_d[3] : data_d[0];
            end else if (dir) begin
                case (shift_amt)
                    2'd1:    carry_d = data_in[0];
                    2'd2:    carry_d = data_in[1];
                    default: carry_d = data_in[2];
                endcase
            end else begin
                case (shift_amt)
                    2'd1:    carry_d = data_in[3];
                    2'd2:    carry_d = data_in[2];
                    default: carry_d = data_in[1];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else if (in_valid) begin
            carry_q <= carry_d;
        end
    end

    assign carry_out = carry_q;
`endif

endmodule

// File: tb/tb_barrel_shifter_4_bit.sv
// Self-checking bench for barrel_shifter_4_bit; carry checks are built only with BARREL_SHIFTER_CARRY_EN.
module tb_barrel_shifter_4_bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic [1:0] shift_amt = 2'd0;
    logic       dir = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] data_out;
    logic       out_valid;
`ifdef BARREL_SHIFTER_CARRY_EN
    logic       carry_out;
`endif

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_data  = 4'd0;
    logic       exp_carry = 1'b0;

    barrel_shifter_4_bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .shift_amt (shift_amt),
        .dir       (dir),
        .mode      (mode),
        .data_out  (data_out),
        .out_valid (out_valid)
`ifdef BARREL_SHIFTER_CARRY_EN
        ,
        .carry_out (carry_out)
`endif
    );

    always #5 clk = ~clk;

    // Reference result computed with integer arithmetic from the operation definitions.
    function automatic logic [3:0] model_data(input int d, input int n, input int right, input int m);
        int sd;
        int r;
        case (m)
            0: r = right ? (d >> n) : (d << n);
            1: r = right ? ((d >> n) | (d << (4 - n))) : ((d << n) | (d >> (4 - n)));
            2: begin
                sd = (d >= 8) ? d - 16 : d;
                r  = right ? (sd >>> n) : (d << n);
            end
            default: r = d;
        endcase
        return 4'(r & 15);
    endfunction

    function automatic logic model_carry(input int d, input int n, input int right, input int m);
        int res;
        if (n == 0 || m == 3) return 1'b0;
        res = int'(model_data(d, n, right, m));
        if (m == 1) return right ? 1'(res >> 3) : 1'(res);
        return right ? 1'(d >> (n - 1)) : 1'(d >> (4 - n));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic [1:0] n,
                         input logic r, input logic [1:0] m);
        in_valid  = v;
        data_in   = d;
        shift_amt = n;
        dir       = r;
        mode      = m;
        if (v && !rst) begin
            exp_data  = model_data(int'(d), int'(n), int'(r), int'(m));
            exp_carry = model_carry(int'(d), int'(n), int'(r), int'(m));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'($urandom_range(1, 15)), 2'd1, 1'b0, 2'd0);
            step();
            checks++;
            if (data_out !== 4'b0000 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: data_out=%b out_valid=%b, required 0000/0", i, data_out, out_valid);
            end
`ifdef BARREL_SHIFTER_CARRY_EN
            checks++;
            if (carry_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_carry: carry_out=%b, required 0", carry_out);
            end
`endif
        end
        rst = 1'b0;
        exp_data = 4'd0;
        exp_carry = 1'b0;
        drive(1'b0, 4'd0, 2'd0, 1'b0, 2'd0);
        step();
        checks++;
        if (data_out !== 4'b0000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: data_out=%b out_valid=%b, required 0000/0", data_out, out_valid);
        end
    endtask

    task automatic test_directed();
        // {data_in, n, dir, mode, expected data, expected carry}
        logic [13:0] tbl [0:6];
        logic [13:0] e;
        tbl[0] = {4'b1011, 2'd1, 1'b0, 2'b00, 4'b0110, 1'b1};
        tbl[1] = {4'b1011, 2'd1, 1'b1, 2'b00, 4'b0101, 1'b1};
        tbl[2] = {4'b1011, 2'd1, 1'b0, 2'b01, 4'b0111, 1'b1};
        tbl[3] = {4'b1011, 2'd1, 1'b1, 2'b01, 4'b1101, 1'b1};
        tbl[4] = {4'b1011, 2'd1, 1'b1, 2'b10, 4'b1101, 1'b1};
        tbl[5] = {4'b1000, 2'd3, 1'b1, 2'b10, 4'b1111, 1'b0};
        tbl[6] = {4'b0110, 2'd2, 1'b0, 2'b01, 4'b1001, 1'b1};
        for (int i = 0; i < 7; i++) begin
            e = tbl[i];
            drive(1'b1, e[13:10], e[9:8], e[7], e[6:5]);
            step();
            checks++;
            if (data_out !== e[4:1] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL directed[%0d]: data_out=%b out_valid=%b, required %b/1", i, data_out, out_valid, e[4:1]);
            end
`ifdef BARREL_SHIFTER_CARRY_EN
            checks++;
            if (carry_out !== e[0]) begin
                errors++;
                $display("FAIL directed_carry[%0d]: carry_out=%b, required %b", i, carry_out, e[0]);
            end
`endif
        end
    endtask

    task automatic test_zero_and_pass();
        for (int m = 0; m < 4; m++) begin
            for (int r = 0; r < 2; r++) begin
                drive(1'b1, 4'b1011, (m == 3) ? 2'd2 : 2'd0, 1'(r), 2'(m));
                step();
                checks++;
                if (data_out !== 4'b1011 || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL identity mode=%0d dir=%0d: data_out=%b out_valid=%b, required 1011/1", m, r, data_out, out_valid);
                end
`ifdef BARREL_SHIFTER_CARRY_EN
                checks++;
                if (carry_out !== 1'b0) begin
                    errors++;
                    $display("FAIL identity_carry mode=%0d dir=%0d: carry_out=%b, required 0", m, r, carry_out);
                end
`endif
            end
        end
    endtask

    task automatic test_random();
        logic v;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
            drive(v, 4'($urandom), 2'($urandom), 1'($urandom), 2'($urandom));
            step();
            checks++;
            if (data_out !== exp_data || out_valid !== v) begin
                errors++;
                $display("FAIL random[%0d]: data_out=%b out_valid=%b, required %b/%b", i, data_out, out_valid, exp_data, v);
            end
`ifdef BARREL_SHIFTER_CARRY_EN
            checks++;
            if (carry_out !== exp_carry) begin
                errors++;
                $display("FAIL random_carry[%0d]: carry_out=%b, required %b", i, carry_out, exp_carry);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        int vcount = 0;
        logic [3:0] last;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'($urandom), 2'($urandom_range(1, 3)), 1'($urandom), 2'($urandom_range(0, 2)));
            step();
            if (out_valid === 1'b1) vcount++;
            checks++;
            if (data_out !== exp_data) begin
                errors++;
                $display("FAIL b2b_data[%0d]: data_out=%b, required %b", i, data_out, exp_data);
            end
        end
        last = exp_data;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'($urandom), 2'($urandom), 1'($urandom), 2'($urandom));
            step();
            if (out_valid === 1'b1) vcount++;
            checks++;
            if (data_out !== last) begin
                errors++;
                $display("FAIL b2b_hold[%0d]: data_out=%b, required %b", i, data_out, last);
            end
        end
        checks++;
        if (vcount != 3) begin
            errors++;
            $display("FAIL b2b_valid_count: out_valid high %0d cycles, required 3", vcount);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'b0111, 2'd1, 1'b0, 2'b00);
        step();
        checks++;
        if (data_out !== 4'b1110 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_op: data_out=%b out_valid=%b, required 1110/1", data_out, out_valid);
        end
        rst = 1'b1;
        drive(1'b1, 4'b1111, 2'd0, 1'b0, 2'b11);
        step();
        checks++;
        if (data_out !== 4'b0000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_with_valid: data_out=%b out_valid=%b, required 0000/0", data_out, out_valid);
        end
`ifdef BARREL_SHIFTER_CARRY_EN
        checks++;
        if (carry_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_with_valid_carry: carry_out=%b, required 0", carry_out);
        end
`endif
        rst = 1'b0;
        exp_data = 4'd0;
        exp_carry = 1'b0;
        drive(1'b0, 4'b1111, 2'd0, 1'b0, 2'b11);
        step();
        checks++;
        if (out_valid !== 1'b0 || data_out !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_idle: data_out=%b out_valid=%b, required 0000/0", data_out, out_valid);
        end
        drive(1'b1, 4'b1001, 2'd2, 1'b1, 2'b01);
        step();
        checks++;
        if (data_out !== 4'b0110 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_after_reset: data_out=%b out_valid=%b, required 0110/1", data_out, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_zero_and_pass();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_4_bit.md
# barrel_shifter_4_bit

4-bit registered barrel shifter supporting logical shift, rotate and arithmetic shift in either direction by 0–3 positions. Inputs are sampled on a qualified clock edge and the result is presented one cycle later with a valid strobe. It serves as a small shift/rotate execution unit in datapath or ALU pipelines.

## Interface
Parameters:
- None. Width is fixed at 4 bits and the shift amount at 2 bits.

Ports:
- `clk`  input  1  System clock; all state updates on the rising edge.
- `rst`  input  1  Reset, synchronous, active-high.
- `in_valid`  input  1  Qualifies `data_in`, `shift_amt`, `dir` and `mode` on this edge.
- `data_in`  input  4  Operand.
- `shift_amt`  input  2  Shift or rotate distance, 0–3.
- `dir`  input  1  Direction: 0 = left, 1 = right.
- `mode`  input  2  Operation: 00 logical, 01 rotate, 10 arithmetic, 11 pass-through.
- `data_out`  output  4  Registered result.
- `out_valid`  output  1  High for one cycle when `data_out` holds a new result.
- `carry_out`  output  1  Last bit shifted or rotated out. Present only with `BARREL_SHIFTER_CARRY_EN`.

## Operation
Results for each `mode`/`dir` combination (n = `shift_amt`):
- Logical, left: `data_in << n`, zero fill.
- Logical, right: `data_in >> n`, zero fill.
- Rotate, left: `data_in` rotated left by n; bits leaving the MSB re-enter at the LSB.
- Rotate, right: `data_in` rotated right by n; bits leaving the LSB re-enter at the MSB.
- Arithmetic, right: `data_in >> n`, filling with `data_in[3]` (sign extension).
- Arithmetic, left: identical to logical left.
- Pass-through (11): `data_out = data_in`, regardless of `dir` and `shift_amt`.

Rules:
- n = 0 returns `data_in` unchanged in every mode.
- The shift network is purely combinational, with no internal state besides the output registers. It is built as two stages (by 1, then by 2) driven by the `shift_amt` bits.

Carry (when enabled):
- n = 0 or pass-through: 0.
- Logical or arithmetic, left: `data_in[4-n]`.
- Logical or arithmetic, right: `data_in[n-1]`.
- Rotate, left: the new `data_out[0]`.
- Rotate, right: the new `data_out[3]`.

## Timing
- Latency is 1 cycle: inputs sampled at edge k with `in_valid`=1 appear on `data_out` (and `carry_out`) after edge k, and `out_valid`=1 during that cycle.
- `in_valid`=0 at an edge: `data_out` and `carry_out` hold their previous values, and `out_valid` goes 0.
- Throughput is one operation per cycle. Back-to-back `in_valid` gives back-to-back `out_valid`.
- There is no backpressure; a result is valid for exactly one cycle.
- `rst`=1 at an edge forces `data_out`=0000, `out_valid`=0 and `carry_out`=0, overriding `in_valid`.
- Reset asserted mid-stream discards the in-flight result; the first valid output comes one cycle after the first qualified input following reset release.

## Configuration
- `BARREL_SHIFTER_CARRY_EN` defined: the `carry_out` port and its register exist, with behaviour as specified under Operation.
- Not defined: the `carry_out` port and its logic are omitted. `data_out` and `out_valid` behave identically.

## Test plan
- `rst`=1 for 2 cycles -> `data_out`=0000, `out_valid`=0, `carry_out`=0.
- `data_in`=1011, n=1, `in_valid`=1; next cycle `out_valid`=1 with `carry_out`=1 in every case:
  - Logical left -> 0110.
  - Logical right -> 0101.
  - Rotate left -> 0111.
  - Rotate right -> 1101.
  - Arithmetic right -> 1101.
- `data_in`=1000, arithmetic right, n=3 -> 1111, `carry_out`=0. `data_in`=0110, rotate left, n=2 -> 1001.
- `data_in`=1011 with n=0 in all modes, and with mode 11 at n=2 -> 1011, `carry_out`=0.
- Issue three back-to-back valid operations, then drop `in_valid`:
  - `out_valid` is high for exactly three consecutive cycles.
  - `data_out` then holds the last result.
- Assert `rst` in the same cycle as a valid input -> `out_valid`=0 next cycle and `data_out`=0000.
